// File: rtl/mem_access_unit.sv
// RV32 load/store access unit: issues one memory access per request over a
// busywait handshake. Optional misaligned trap: define MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_read,
  input  logic        Req_write,
  input  logic [31:0] Req_addr,
  input  logic [31:0] Req_wdata,
  input  logic [2:0]  Req_func3,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] Load_data,
  output logic        Fault,
  output logic [1:0]  Fault_cause,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Write_data,
  output logic [2:0]  Mem_Func3,
  input  logic [31:0] Mem_Read_data,
  input  logic        Mem_Busywait
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            seen_q;
  logic            load_q;
  logic            done_q;
  logic            fault_q;
  logic [1:0]      cause_q;
  logic [31:0]     ldata_q;
  logic            rd_q;
  logic            wr_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;

  logic req;
  logic illegal;
  logic misal;
  logic tmo_hit;

  assign req = Req_read | Req_write;

  assign illegal = (Req_read & Req_write)
                 | (Req_read & (Req_func3 == 3'b011
                              | Req_func3 == 3'b110
                              | Req_func3 == 3'b111))
                 | (Req_write & (Req_func3 > 3'b010));

`ifdef MISALIGN_TRAP_EN
  assign misal = (Req_func3[1:0] == 2'b01 & Req_addr[0])
               | (Req_func3[1:0] == 2'b10 & (|Req_addr[1:0]));
`else
  assign misal = 1'b0;
`endif

  assign cnt_d   = cnt_q + CW'(1);
  assign tmo_hit = (cnt_d == CW'(TIMEOUT));

  assign Stall = (state_q == S_IDLE & req)
               | (state_q == S_ISSUE)
               | (state_q == S_WAIT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      ldata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (illegal) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
              cause_q <= 2'b01;
            end else if (misal) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
              cause_q <= 2'b11;
            end else begin
              state_q <= S_ISSUE;
              addr_q  <= Req_addr;
              wdata_q <= Req_wdata;
              f3_q    <= Req_func3;
              load_q  <= Req_read;
              rd_q    <= Req_read;
              wr_q    <= Req_write;
              cnt_q   <= '0;
              seen_q  <= 1'b0;
              cause_q <= 2'b00;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (Mem_Busywait) begin
            seen_q <= 1'b1;
            if (load_q) ldata_q <= Mem_Read_data;
          end
          // completion wins over timeout on the same edge
          if (!Mem_Busywait && seen_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            cause_q <= 2'b10;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Done           = done_q;
  assign Fault          = fault_q;
  assign Fault_cause    = cause_q;
  assign Load_data      = ldata_q;
  assign Mem_Read       = rd_q;
  assign Mem_Write      = wr_q;
  assign Mem_Address    = addr_q;
  assign Mem_Write_data = wdata_q;
  assign Mem_Func3      = f3_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level model
// and a per-cycle compare process.
module tb_mem_access_unit;

  localparam int TO = 6;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req_read;
  logic        Req_write;
  logic [31:0] Req_addr;
  logic [31:0] Req_wdata;
  logic [2:0]  Req_func3;
  logic        Stall;
  logic        Done;
  logic [31:0] Load_data;
  logic        Fault;
  logic [1:0]  Fault_cause;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_data;
  logic [2:0]  Mem_Func3;
  logic [31:0] Mem_Read_data;
  logic        Mem_Busywait;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req_read(Req_read), .Req_write(Req_write),
    .Req_addr(Req_addr), .Req_wdata(Req_wdata),
    .Req_func3(Req_func3), .Stall(Stall), .Done(Done),
    .Load_data(Load_data), .Fault(Fault),
    .Fault_cause(Fault_cause), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
    .Mem_Write_data(Mem_Write_data), .Mem_Func3(Mem_Func3),
    .Mem_Read_data(Mem_Read_data),
    .Mem_Busywait(Mem_Busywait)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        chk_mem = 1'b0;
  logic        e_stall, e_done, e_fault, e_rd, e_wr;
  logic [1:0]  e_cause;
  logic [31:0] e_ld, e_addr, e_wdata;
  logic [2:0]  e_f3;

  logic [31:0] mem [0:255];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, want,
               $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("stall", 32'(Stall), 32'(e_stall));
      chk("done", 32'(Done), 32'(e_done));
      chk("fault", 32'(Fault), 32'(e_fault));
      chk("cause", 32'(Fault_cause), 32'(e_cause));
      chk("load_data", Load_data, e_ld);
      chk("mem_read", 32'(Mem_Read), 32'(e_rd));
      chk("mem_write", 32'(Mem_Write), 32'(e_wr));
      if (chk_mem) begin
        chk("mem_addr", Mem_Address, e_addr);
        chk("mem_wdata", Mem_Write_data, e_wdata);
        chk("mem_func3", 32'(Mem_Func3), 32'(e_f3));
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] mload(logic [31:0] a,
                                        logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem[a[9:2]];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic mstore(logic [31:0] a, logic [31:0] d,
                        logic [2:0] f3);
    case (f3[1:0])
      2'b00:   mem[a[9:2]][8*a[1:0] +: 8] = d[7:0];
      2'b01:   mem[a[9:2]][16*a[1] +: 16] = d[15:0];
      default: mem[a[9:2]] = d;
    endcase
  endtask

  task automatic idle_exp();
    Req_read = 0; Req_write = 0;
    Mem_Busywait = 0;
    e_stall = 0; e_done = 0; e_fault = 0;
    e_rd = 0; e_wr = 0; chk_mem = 0;
  endtask

  // mode 0: nominal memory, 1: never busy, 2: reset pulsed in WAIT
  task automatic txn(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input int mode);
    logic        ill, mis;
    logic [31:0] ldv;
    ill = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7))
       || (wr && f3 > 2);
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (f3[1:0] == 2'b01 && a[0])
       || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
    Req_read = rd; Req_write = wr;
    Req_addr = a; Req_wdata = d; Req_func3 = f3;
    e_stall = 1; e_done = 0; e_fault = 0;
    e_rd = 0; e_wr = 0; chk_mem = 0;
    cyc();
    if (ill || mis) begin
      Req_read = 0; Req_write = 0;
      e_stall = 0; e_fault = 1;
      e_cause = ill ? 2'b01 : 2'b11;
      cyc();
      idle_exp();
      cyc();
      return;
    end
    e_rd = rd; e_wr = wr; e_cause = 2'b00;
    chk_mem = 1; e_addr = a; e_wdata = d; e_f3 = f3;
    if (wr) mstore(a, d, f3);
    ldv = mload(a, f3);
    cyc();
    e_rd = 0; e_wr = 0;
    if (mode == 1) begin
      for (int i = 0; i < TO; i++) cyc();
      Req_read = 0; Req_write = 0;
      e_stall = 0; e_fault = 1; e_cause = 2'b10; chk_mem = 0;
      cyc();
      idle_exp();
      cyc();
      return;
    end
    Mem_Busywait = 1;
    Mem_Read_data = rd ? ldv : 32'hA5A5A5A5;
    if (mode == 2) begin
      Reset = 1;
      cyc();
      Reset = 0;
      idle_exp();
      e_ld = 0; e_cause = 0;
      chk_mem = 1; e_addr = 0; e_wdata = 0; e_f3 = 0;
      cyc();
      chk_mem = 0;
      cyc();
      return;
    end
    cyc();
    Mem_Busywait = 0;
    Mem_Read_data = 32'h5A5A5A5A;
    if (rd) e_ld = ldv;
    cyc();
    Req_read = 0; Req_write = 0;
    e_stall = 0; e_done = 1;
    cyc();
    idle_exp();
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    Reset = 1;
    Req_addr = 0; Req_wdata = 0; Req_func3 = 0;
    Mem_Read_data = 0;
    idle_exp();
    e_cause = 0; e_ld = 0;
    e_addr = 0; e_wdata = 0; e_f3 = 0;
    cyc();
    chk_en = 1; chk_mem = 1;
    cyc();
    Reset = 0;
    chk_mem = 0;
    cyc();

    txn(0, 1, 32'h40, 32'hDEADBEEF, 3'b010, 0);
    txn(1, 0, 32'h40, 32'h0, 3'b010, 0);
    chk("lw_lit", Load_data, 32'hDEADBEEF);
    txn(1, 0, 32'h43, 32'h0, 3'b000, 0);
    chk("lb_lit", Load_data, 32'hFFFFFFDE);
    txn(1, 0, 32'h43, 32'h0, 3'b100, 0);
    chk("lbu_lit", Load_data, 32'h000000DE);
    txn(0, 1, 32'h46, 32'h00009234, 3'b001, 0);
    txn(1, 0, 32'h46, 32'h0, 3'b001, 0);
    chk("lh_lit", Load_data, 32'hFFFF9234);
    txn(1, 0, 32'h46, 32'h0, 3'b101, 0);
    chk("lhu_lit", Load_data, 32'h00009234);
    txn(0, 1, 32'h44, 32'h00000080, 3'b000, 0);
    chk("sb_keeps_ld", Load_data, 32'h00009234);
    txn(1, 0, 32'h44, 32'h0, 3'b000, 0);
    chk("lb_neg_lit", Load_data, 32'hFFFFFF80);

    txn(1, 1, 32'h40, 32'h0, 3'b010, 0);
    chk("ill_cause_lit", 32'(Fault_cause), 32'h1);
    txn(1, 0, 32'h40, 32'h0, 3'b011, 0);
    txn(0, 1, 32'h40, 32'h0, 3'b100, 0);
    chk("ill_keeps_ld", Load_data, 32'hFFFFFF80);

    txn(1, 0, 32'h40, 32'h0, 3'b010, 1);
    chk("tmo_cause_lit", 32'(Fault_cause), 32'h2);
    txn(0, 1, 32'h48, 32'h11223344, 3'b010, 0);
    chk("cause_cleared", 32'(Fault_cause), 32'h0);

    txn(1, 0, 32'h42, 32'h0, 3'b010, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_cause_lit", 32'(Fault_cause), 32'h3);
`else
    chk("mis_lw_lit", Load_data, 32'hDEADBEEF);
`endif
    txn(1, 0, 32'h41, 32'h0, 3'b001, 0);

    txn(1, 0, 32'h48, 32'h0, 3'b010, 2);
    chk("rst_ld_lit", Load_data, 32'h0);
    txn(1, 0, 32'h48, 32'h0, 3'b010, 0);
    chk("post_rst_lw", Load_data, 32'h11223344);

    cyc();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max WAIT-state cycles before a timeout fault.
REQ-002 SHALL have port Clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports Req_read / Req_write  in  1 each  load / store request from the EX/MEM pipeline register.
REQ-005 SHALL have ports Req_addr  in  32  byte address; Req_wdata  in  32  store data; Req_func3  in  3  RV32 load/store funct3.
REQ-006 SHALL have port Stall  out  1  freezes the pipeline; the pipeline holds all Req_* stable while Stall=1.
REQ-007 SHALL have ports Done  out  1  one-cycle completion pulse; Load_data  out  32  loaded value.
REQ-008 SHALL have ports Fault  out  1  one-cycle fault pulse; Fault_cause  out  2  01=illegal, 10=timeout, 11=misaligned.
REQ-009 SHALL have memory-side ports Mem_Read, Mem_Write  out  1; Mem_Address, Mem_Write_data  out  32; Mem_Func3  out  3.
REQ-010 SHALL have memory-side inputs Mem_Read_data  in  32 and Mem_Busywait  in  1.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, DONE and FAULT.
REQ-012 IDLE: a valid request SHALL register Req_addr, Req_wdata and Req_func3 into Mem_Address, Mem_Write_data and Mem_Func3, clear the timeout counter and seen-busy flag, and move to ISSUE.
REQ-013 A request SHALL be illegal if Req_read and Req_write are both 1, if a read uses func3 011, 110 or 111, or if a write uses func3 above 010; an illegal request SHALL go to FAULT with cause 01 and no memory access.
REQ-014 ISSUE: Mem_Read or Mem_Write SHALL be 1 for exactly this one cycle, then the unit SHALL move to WAIT; both strobes SHALL be 0 in every other state.
REQ-015 Mem_Address, Mem_Write_data and Mem_Func3 SHALL stay stable from ISSUE through DONE.
REQ-016 WAIT: on each edge with Mem_Busywait=1, the unit SHALL set seen-busy and, for a load, capture Mem_Read_data into Load_data.
REQ-017 WAIT: on an edge with Mem_Busywait=0 and seen-busy=1, the unit SHALL move to DONE.
REQ-018 WAIT: the timeout counter SHALL increment each WAIT cycle; on reaching TIMEOUT without completion, the unit SHALL move to FAULT with cause 10.
REQ-019 Completion SHALL take priority over timeout on the same edge.
REQ-020 Stall SHALL be combinational: 1 when (IDLE and a request is present) or in ISSUE or WAIT; 0 in DONE and FAULT.
REQ-021 DONE: Done=1 and Stall=0 for one cycle, then the unit SHALL return to IDLE without sampling Req_*; the next request is accepted from the following IDLE cycle.
REQ-022 Nominal memory (busy exactly one cycle after issue) SHALL give Stall for 4 cycles and Done in the 5th cycle after the request first appears.
REQ-023 Load_data SHALL be unchanged by stores and faults and held until the next load capture.
REQ-024 FAULT: Fault=1 and Stall=0 for one cycle, then the unit SHALL return to IDLE; Fault_cause SHALL hold until the next request leaves IDLE.

Reset
REQ-025 Reset SHALL force IDLE and zero Stall-state, Done, Fault, Fault_cause, Load_data, all Mem_* outputs, the timeout counter and seen-busy.
REQ-026 Reset asserted during ISSUE or WAIT SHALL abort the access: strobes are 0 from the next cycle and no Done or Fault pulse is produced.

Configuration
REQ-027 With macro MISALIGN_TRAP_EN defined, a halfword access with Req_addr[0]=1, or a word access with Req_addr[1:0]≠00, SHALL go to FAULT with cause 11 and no memory access.
REQ-028 Without MISALIGN_TRAP_EN, misaligned accesses SHALL be issued unchanged and cause 11 SHALL never be produced.

Verification
REQ-029 SW addr 0x40, data 0xDEADBEEF, then LW 0x40 -> Done in the 5th cycle and Load_data=0xDEADBEEF.
REQ-030 LB at 0x43 after that store -> Load_data=0xFFFFFFDE; LBU at 0x43 -> 0x000000DE.
REQ-031 Req_read=Req_write=1 -> Fault pulse, cause 01, Mem_Read and Mem_Write never asserted.
REQ-032 Memory model holds Mem_Busywait=0 forever -> Fault with cause 10 exactly TIMEOUT WAIT cycles after ISSUE.
REQ-033 LW at 0x42 -> with MISALIGN_TRAP_EN: Fault, cause 11; without it: Done, no Fault.
REQ-034 Reset pulsed in WAIT -> Stall=0 and all outputs 0 the next cycle, no Done; a new LW afterwards completes normally.
